// File: rtl/branch_pkg.sv
// Shared encodings for ID-stage branch resolution: decoded conditions,
// comparator codes and resolver FSM states.
package branch_pkg;

  localparam logic [2:0] COND_BEQ = 3'b000;
  localparam logic [2:0] COND_BNE = 3'b001;
  localparam logic [2:0] COND_BLT = 3'b010;
  localparam logic [2:0] COND_BGT = 3'b011;
  localparam logic [2:0] COND_BLE = 3'b100;
  localparam logic [2:0] COND_BGE = 3'b101;
  localparam logic [2:0] COND_JMP = 3'b110;
  localparam logic [2:0] COND_NOP = 3'b111;

  localparam logic [1:0] CMP_LT   = 2'b00;
  localparam logic [1:0] CMP_GT   = 2'b01;
  localparam logic [1:0] CMP_EQ   = 2'b10;
  localparam logic [1:0] CMP_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational taken decision from decoded condition and comparator code.
// A conditional branch seeing CMP_NONE is reported as an error and not taken.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int COND_WIDTH    = 3,
  parameter int CONTROL_WIDTH = 2
) (
  input  logic [COND_WIDTH-1:0]    cond,
  input  logic [CONTROL_WIDTH-1:0] code,
  output logic                     taken,
  output logic                     err
);

  logic is_lt, is_gt, is_eq, is_none;

  assign is_lt   = (code == CMP_LT);
  assign is_gt   = (code == CMP_GT);
  assign is_eq   = (code == CMP_EQ);
  assign is_none = (code == CMP_NONE);

  always_comb begin
    taken = 1'b0;
    err   = 1'b0;
    case (cond)
      COND_BEQ: taken = is_eq;
      COND_BNE: taken = is_lt | is_gt;
      COND_BLT: taken = is_lt;
      COND_BGT: taken = is_gt;
      COND_BLE: taken = is_lt | is_eq;
      COND_BGE: taken = is_gt | is_eq;
      COND_JMP: taken = 1'b1;
      default:  taken = 1'b0;
    endcase
    // JMP ignores the code; NOP never reaches resolution
    if (cond != COND_JMP && cond != COND_NOP)
      err = is_none;
  end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolver: waits for forwarded operands, decides taken,
// issues a one-cycle redirect/flush and keeps saturating branch statistics.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int CONTROL_WIDTH = 2,
  parameter int COND_WIDTH    = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     br_valid,
  input  logic [COND_WIDTH-1:0]    br_cond,
  input  logic [CONTROL_WIDTH-1:0] branch,
  input  logic                     operands_ready,
  input  logic [DATA_WIDTH-1:0]    pc_plus1,
  input  logic [DATA_WIDTH-1:0]    offset,
  output logic                     stall,
  output logic                     redirect_valid,
  output logic [DATA_WIDTH-1:0]    redirect_pc,
  output logic                     flush,
  output logic                     cond_err,
  output logic [CNT_WIDTH-1:0]     br_count,
  output logic [CNT_WIDTH-1:0]     taken_count
);

  state_e state, state_nx;

  logic [COND_WIDTH-1:0] cond_q, cond_sel;
  logic [DATA_WIDTH-1:0] pc_q, off_q, pc_sel, off_sel, target;
  logic                  active, resolve, capture, taken, err;

  assign active = br_valid && (br_cond != COND_NOP);

  // In WAIT the ID register may already hold something else; use the copy
  always_comb begin
    cond_sel = br_cond;
    pc_sel   = pc_plus1;
    off_sel  = offset;
    if (state == ST_WAIT) begin
      cond_sel = cond_q;
      pc_sel   = pc_q;
      off_sel  = off_q;
    end
  end

  branch_cond_eval #(
    .COND_WIDTH   (COND_WIDTH),
    .CONTROL_WIDTH(CONTROL_WIDTH)
  ) u_eval (
    .cond (cond_sel),
    .code (branch),
    .taken(taken),
    .err  (err)
  );

  assign target  = pc_sel + off_sel;
  assign resolve = operands_ready &&
                   ((state == ST_IDLE && active) || state == ST_WAIT);
  assign capture = (state == ST_IDLE) && active && !operands_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (resolve)      state_nx = taken ? ST_FLUSH : ST_IDLE;
        else if (capture) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (resolve) state_nx = taken ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    stall          = capture || (state == ST_WAIT);
    redirect_valid = (state == ST_FLUSH);
    flush          = (state == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cond_q      <= '0;
      pc_q        <= '0;
      off_q       <= '0;
      redirect_pc <= '0;
      cond_err    <= 1'b0;
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      if (capture) begin
        cond_q <= br_cond;
        pc_q   <= pc_plus1;
        off_q  <= offset;
      end
      if (resolve) begin
        if (br_count != '1) br_count <= br_count + 1'b1;
        if (err) cond_err <= 1'b1;
        if (taken) begin
          redirect_pc <= target;
          if (taken_count != '1) taken_count <= taken_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: expected redirect targets are queued
// when a branch resolves and popped when redirect_valid is observed.
module tb_branch_resolve;
  import branch_pkg::*;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          br_valid;
  logic [2:0]    br_cond;
  logic [1:0]    branch;
  logic          operands_ready;
  logic [DW-1:0] pc_plus1, offset;
  logic          stall, redirect_valid, flush, cond_err;
  logic [DW-1:0] redirect_pc;
  logic [CW-1:0] br_count, taken_count;

  int total = 0;
  int bad   = 0;
  int m_br, m_tk;
  logic m_err;
  logic [DW-1:0] exp_q[$];

  branch_resolve #(.DATA_WIDTH(DW), .CONTROL_WIDTH(2), .COND_WIDTH(3), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_cond(br_cond), .branch(branch),
    .operands_ready(operands_ready), .pc_plus1(pc_plus1), .offset(offset),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .cond_err(cond_err), .br_count(br_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  function automatic logic model_taken(input logic [2:0] c, input logic [1:0] k);
    case (c)
      3'b000:  return k == 2'b10;
      3'b001:  return k == 2'b00 || k == 2'b01;
      3'b010:  return k == 2'b00;
      3'b011:  return k == 2'b01;
      3'b100:  return k == 2'b00 || k == 2'b10;
      3'b101:  return k == 2'b01 || k == 2'b10;
      3'b110:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: every redirect must match the oldest queued target
  always @(negedge clk) begin
    logic [DW-1:0] e;
    total++;
    if (flush !== redirect_valid) begin
      bad++;
      $display("FAIL flush_eq_redirect flush=%b redirect_valid=%b", flush, redirect_valid);
    end
    if (redirect_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_redirect pc=%h", redirect_pc);
      end else begin
        e = exp_q.pop_front();
        if (redirect_pc !== e) begin
          bad++;
          $display("FAIL redirect_pc got=%h exp=%h", redirect_pc, e);
        end
      end
      total++;
      if (stall !== 1'b0) begin
        bad++;
        $display("FAIL stall_in_flush got=%b exp=0", stall);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_valid = 1'b0; br_cond = COND_NOP; branch = CMP_NONE;
    operands_ready = 1'b0; pc_plus1 = '0; offset = '0;
  endtask

  // Account for a resolution happening at the coming edge
  task automatic model_resolve(input logic [2:0] c, input logic [1:0] k,
                               input logic [DW-1:0] pc, input logic [DW-1:0] off);
    if (m_br < SAT) m_br++;
    if (model_taken(c, k)) begin
      if (m_tk < SAT) m_tk++;
      exp_q.push_back(pc + off);
    end
    if (c != COND_JMP && k == CMP_NONE) m_err = 1'b1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] k,
                       input logic [DW-1:0] pc, input logic [DW-1:0] off);
    br_valid = 1'b1; br_cond = c; branch = k; operands_ready = 1'b1;
    pc_plus1 = pc; offset = off;
    model_resolve(c, k, pc, off);
    tick();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    m_br = 0; m_tk = 0; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({redirect_valid, flush, cond_err, stall} !== 4'b0 || br_count !== '0 ||
        taken_count !== '0 || redirect_pc !== '0) begin
      bad++;
      $display("FAIL reset rv=%b fl=%b err=%b st=%b br=%0d tk=%0d pc=%h exp all zero",
               redirect_valid, flush, cond_err, stall, br_count, taken_count, redirect_pc);
    end
    tick();
  endtask

  task automatic test_taken_beq();
    do_reset();
    issue(COND_BEQ, CMP_EQ, 16'h0010, 16'h0005);
    idle();
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b1 || br_count !== 4'd1 || taken_count !== 4'd1) begin
      bad++;
      $display("FAIL beq_taken rv=%b br=%0d tk=%0d exp rv=1 br=1 tk=1",
               redirect_valid, br_count, taken_count);
    end
    tick();
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL beq_one_cycle rv=%b exp=0", redirect_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    br_valid = 1'b1; br_cond = COND_BNE; branch = CMP_EQ; operands_ready = 1'b1;
    pc_plus1 = 16'h0040; offset = 16'h0008;
    model_resolve(COND_BNE, CMP_EQ, 16'h0040, 16'h0008);
    @(negedge clk);
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall0 got=%b exp=0", stall); end
    tick();
    br_cond = COND_BLT; branch = CMP_GT; pc_plus1 = 16'h0041;
    model_resolve(COND_BLT, CMP_GT, 16'h0041, 16'h0008);
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stall1 stall=%b rv=%b exp 0 0", stall, redirect_valid);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if (br_count !== 4'(m_br) || taken_count !== 4'(m_tk) || redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_counts br=%0d tk=%0d rv=%b exp br=%0d tk=%0d rv=0",
               br_count, taken_count, redirect_valid, m_br, m_tk);
    end
    tick();
  endtask

  task automatic test_wait();
    do_reset();
    br_valid = 1'b1; br_cond = COND_BGE; branch = CMP_NONE; operands_ready = 1'b0;
    pc_plus1 = 16'h0100; offset = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        br_valid = i[0]; br_cond = COND_BEQ; branch = CMP_LT;
        pc_plus1 = 16'($urandom); offset = 16'($urandom);
      end
      if (i == 3) begin
        operands_ready = 1'b1; branch = CMP_EQ;
        model_resolve(COND_BGE, CMP_EQ, 16'h0100, 16'hFFFE);
      end
      @(negedge clk);
      total++;
      if (stall !== 1'b1 || redirect_valid !== 1'b0) begin
        bad++;
        $display("FAIL wait_stall cyc=%0d stall=%b rv=%b exp 1 0", i, stall, redirect_valid);
      end
      tick();
    end
    idle();
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b1 || stall !== 1'b0 || taken_count !== 4'd1) begin
      bad++;
      $display("FAIL wait_redirect rv=%b stall=%b tk=%0d exp 1 0 1",
               redirect_valid, stall, taken_count);
    end
    tick();
  endtask

  task automatic test_jmp_and_err();
    do_reset();
    issue(COND_JMP, CMP_NONE, 16'hFFFF, 16'h0003);
    idle();
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b1 || cond_err !== 1'b0) begin
      bad++;
      $display("FAIL jmp_wrap rv=%b err=%b exp rv=1 err=0", redirect_valid, cond_err);
    end
    tick();
    issue(COND_BEQ, CMP_NONE, 16'h0200, 16'h0004);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (cond_err !== m_err || redirect_valid !== 1'b0 || br_count !== 4'(m_br)) begin
        bad++;
        $display("FAIL cond_err cyc=%0d err=%b rv=%b br=%0d exp err=%b rv=0 br=%0d",
                 i, cond_err, redirect_valid, br_count, m_err, m_br);
      end
      tick();
    end
  endtask

  task automatic test_flush_ignore_and_reset();
    do_reset();
    issue(COND_BEQ, CMP_EQ, 16'h0020, 16'h0010);
    // Wrong-path branch presented during the flush cycle; no model update
    br_valid = 1'b1; br_cond = COND_BEQ; branch = CMP_EQ; operands_ready = 1'b1;
    pc_plus1 = 16'h0777; offset = 16'h0001;
    tick();
    idle();
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b0 || br_count !== 4'd1 || taken_count !== 4'd1) begin
      bad++;
      $display("FAIL flush_ignore rv=%b br=%0d tk=%0d exp 0 1 1",
               redirect_valid, br_count, taken_count);
    end
    tick();
    br_valid = 1'b1; br_cond = COND_BLT; branch = CMP_NONE; operands_ready = 1'b0;
    pc_plus1 = 16'h0300; offset = 16'h0010;
    tick();
    rst = 1'b1; operands_ready = 1'b1; branch = CMP_LT;
    tick();
    rst = 1'b0;
    idle();
    m_br = 0; m_tk = 0; m_err = 1'b0;
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b0 || stall !== 1'b0 || br_count !== '0 || taken_count !== '0) begin
      bad++;
      $display("FAIL reset_in_wait rv=%b stall=%b br=%0d tk=%0d exp all 0",
               redirect_valid, stall, br_count, taken_count);
    end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < SAT + 2; i++) begin
      issue(COND_JMP, CMP_EQ, 16'(i * 3), 16'h0001);
      idle();
      tick();
    end
    @(negedge clk);
    total++;
    if (br_count !== 4'hF || taken_count !== 4'hF) begin
      bad++;
      $display("FAIL saturate br=%h tk=%h exp F F", br_count, taken_count);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_taken_beq();
    test_back_to_back();
    test_wait();
    test_jmp_and_err();
    test_flush_ignore_and_reset();
    test_saturate();
    tick(); tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_redirects left=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
